dec_ct_unpack_decomp: RTL and testbench

- Front end of the decryption datapath.
- Consumes the compressed ciphertext vector u (Kyber512, k=2, du=10, 640 bytes) as a 32-bit word stream.
- Unpacks 10-bit coefficients, decompresses each to 12 bits mod q, and writes 64 words of 96 bits (8 coefficients each) into the polynomial BRAM through the Unpack-stage write port of the decryption BRAM mux.

---
 rtl/kyber_dec_pkg.sv | 31 +++
 rtl/decomp_du10.sv | 16 +
 rtl/dec_ct_unpack_decomp.sv | 135 +++++++++++++
 tb/tb_dec_ct_unpack_decomp.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/kyber_dec_pkg.sv
// Shared constants and encodings for the Kyber decryption datapath.
package kyber_dec_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int DU          = 10;
    localparam int COEF_W      = 12;
    localparam int N_WORDS_IN  = 160;
    localparam int N_WORDS_OUT = 64;
    localparam int BUF_W       = 112;  // worst case: 79 residual bits + one 32-bit word
    localparam int EXT_W       = 80;   // 8 coefficients x DU bits per BRAM word
    localparam int N_COEF      = 8;

    // Unpack front-end FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } unpack_state_e;

    // Top-level stage codes, shared with the decryption BRAM mux.
    typedef enum logic [2:0] {
        STG_IDLE   = 3'd0,
        STG_UNPACK = 3'd1,
        STG_NTT    = 3'd2,
        STG_PACC   = 3'd3,
        STG_INTT   = 3'd4,
        STG_SUB    = 3'd5
    } dec_stage_e;

endpackage

// File: rtl/decomp_du10.sv
// Combinational Kyber decompression of one 10-bit coefficient: round(x*q/1024).
module decomp_du10
    import kyber_dec_pkg::*;
(
    input  logic [DU-1:0]     i_x,
    output logic [COEF_W-1:0] o_y
);

    // 1023*3329 + 512 still fits in 22 bits; the result never exceeds 3326,
    // so no modular reduction is needed.
    logic [21:0] w_prod;

    assign w_prod = 22'(i_x) * 22'(KYBER_Q) + 22'd512;
    assign o_y    = w_prod[21:10];

endmodule

// File: rtl/dec_ct_unpack_decomp.sv
// Ciphertext u unpacker: 32-bit word stream -> 10-bit coefficients ->
// decompressed 12-bit values, written 8 per word into the polynomial BRAM.
module dec_ct_unpack_decomp
    import kyber_dec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        ct_valid,
    output logic        ct_ready,
    input  logic [31:0] ct_data,
    output logic        ct_outready,
    output logic [5:0]  ct_WAd,
    output logic [95:0] Bp_ct_WData,
    output logic        done
);

    unpack_state_e r_state, w_state_nx;

    logic [BUF_W-1:0]  r_buf;
    logic [6:0]        r_fill;
    logic [7:0]        r_in_cnt;
    logic [EXT_W-1:0]  r_s1;
    logic              r_s1_v;
    logic [95:0]       r_wdata;
    logic              r_outready;
    logic [5:0]        r_wad;
    logic [5:0]        r_addr;
    logic              r_done;

    logic              w_ready, w_acc, w_ext;
    logic [BUF_W-1:0]  w_buf_sh, w_buf_nx;
    logic [6:0]        w_fill_sh, w_fill_nx;
    logic [N_COEF-1:0][COEF_W-1:0] w_y;

    assign w_ready = (r_state == ST_LOAD) && (r_in_cnt < 8'(N_WORDS_IN)) && (r_fill < 7'd80);
    assign w_acc   = ct_valid && w_ready;
    assign w_ext   = (r_state == ST_LOAD) && (r_fill >= 7'd80);

    // Buffer update: drop the extracted 80 bits first, then append the new
    // word right above the remaining valid bits.
    always_comb begin
        w_buf_sh  = w_ext ? (r_buf >> EXT_W) : r_buf;
        w_fill_sh = w_ext ? (r_fill - 7'd80) : r_fill;
        w_buf_nx  = w_buf_sh;
        w_fill_nx = w_fill_sh;
        if (w_acc) begin
            w_buf_nx  = w_buf_sh | ({80'b0, ct_data} << w_fill_sh);
            w_fill_nx = w_fill_sh + 7'd32;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nx = ST_LOAD;
            ST_LOAD:  if (r_in_cnt == 8'(N_WORDS_IN) && r_fill == 7'd0) w_state_nx = ST_FLUSH;
            ST_FLUSH: if (r_outready && r_wad == 6'd63) w_state_nx = ST_DONE;
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nx;
    end

    // Bit buffer, fill level, input count and stage-1 capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_buf    <= '0;
            r_fill   <= '0;
            r_in_cnt <= '0;
            r_s1     <= '0;
            r_s1_v   <= 1'b0;
        end else begin
            r_s1_v <= w_ext;
            if (w_ext) r_s1 <= r_buf[EXT_W-1:0];
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_buf    <= '0;
                    r_fill   <= '0;
                    r_in_cnt <= '0;
                end
            end else if (r_state == ST_LOAD) begin
                r_buf  <= w_buf_nx;
                r_fill <= w_fill_nx;
                if (w_acc) r_in_cnt <= r_in_cnt + 8'd1;
            end
        end
    end

    // Eight decompressors on the stage-1 word.
    for (genvar g = 0; g < N_COEF; g++) begin : g_dec
        decomp_du10 u_dec (
            .i_x (r_s1[g*DU +: DU]),
            .o_y (w_y[g])
        );
    end

    // Stage 2: register the BRAM write; address advances once per write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outready <= 1'b0;
            r_wdata    <= '0;
            r_wad      <= '0;
            r_addr     <= '0;
        end else begin
            r_outready <= r_s1_v;
            if (r_s1_v) begin
                r_wdata <= w_y;
                r_wad   <= r_addr;
                r_addr  <= r_addr + 6'd1;
            end else if (r_state == ST_IDLE && start) begin
                r_addr  <= '0;
            end
        end
    end

    // Registered completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_done <= 1'b0;
        else     r_done <= (r_state == ST_DONE);
    end

    assign ct_ready    = w_ready;
    assign ct_outready = r_outready;
    assign ct_WAd      = r_wad;
    assign Bp_ct_WData = r_wdata;
    assign done        = r_done;

endmodule

// File: tb/tb_dec_ct_unpack_decomp.sv
// Directed bench for the ciphertext unpack/decompress front end.
module tb_dec_ct_unpack_decomp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ct_valid = 1'b0;
    logic        ct_ready;
    logic [31:0] ct_data = '0;
    logic        ct_outready;
    logic [5:0]  ct_WAd;
    logic [95:0] Bp_ct_WData;
    logic        done;

    int nvec = 0;
    int nerr = 0;

    logic [31:0]   mem [160];
    logic [5119:0] gbits;

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    logic [5:0]  wad_q [$];
    logic [95:0] dat_q [$];

    dec_ct_unpack_decomp dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ct_valid    (ct_valid),
        .ct_ready    (ct_ready),
        .ct_data     (ct_data),
        .ct_outready (ct_outready),
        .ct_WAd      (ct_WAd),
        .Bp_ct_WData (Bp_ct_WData),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Record every write and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ct_outready) begin
            wad_q.push_back(ct_WAd);
            dat_q.push_back(Bp_ct_WData);
            last_wr_cyc <= cyc;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] gold(input int w);
        logic [95:0] r;
        int x, y;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            x = int'(gbits[(w*8+j)*10 +: 10]);
            y = (x * 3329 + 512) >> 10;
            r[j*12 +: 12] = 12'(y);
        end
        return r;
    endfunction

    task automatic clear_log();
        wad_q.delete();
        dat_q.delete();
        done_cnt = 0;
    endtask

    // Start a run and stream mem[] in; optionally abort once enough writes
    // have been seen. The ready line is checked against a fill-level model.
    task automatic send(input bit gaps, input int abort_at);
        int idx, fill_m, n;
        bit exp_rdy, acc, ext;
        for (int w = 0; w < 160; w++) gbits[w*32 +: 32] = mem[w];
        clear_log();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        idx = 0; fill_m = 0; n = 0;
        while (idx < 160 && n < 3000) begin
            if (abort_at > 0 && wad_q.size() >= abort_at) break;
            ct_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ct_data  = mem[idx];
            @(negedge clk);
            exp_rdy = (fill_m < 80);
            chk("ct_ready", ct_ready, exp_rdy);
            acc = ct_valid && exp_rdy;
            ext = (fill_m >= 80);
            fill_m = fill_m - (ext ? 80 : 0) + (acc ? 32 : 0);
            @(posedge clk); #1;
            if (acc) idx++;
            n++;
        end
        if (abort_at == 0) begin
            chk("words_accepted", idx, 160);
            ct_valid = 1'b1;
            @(negedge clk);
            chk("excess_ready", ct_ready, 1'b0);
            @(posedge clk); #1;
        end
        ct_valid = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_nwrites"}, wad_q.size(), 64);
        chk({tag, "_done_lat"}, done_cyc - last_wr_cyc, 2);
        for (int i = 0; i < 64 && i < wad_q.size(); i++) begin
            chk({tag, "_wad"}, wad_q[i], i);
            chk({tag, "_wdata"}, dat_q[i], gold(i));
        end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ct_ready, 1'b0);
        chk("rst_outready", ct_outready, 1'b0);
        chk("rst_wad", ct_WAd, 6'd0);
        chk("rst_wdata", Bp_ct_WData, 96'd0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        // Start ignored while idle without a pulse: no activity.
        repeat (3) @(posedge clk);
        #1 chk("idle_ready", ct_ready, 1'b0);

        // All-zero ciphertext.
        for (int i = 0; i < 160; i++) mem[i] = 32'h0;
        send(1'b0, 0);
        finish_run("zero");

        // Single low bit set: coefficient 0 = 1 -> 3.
        mem[0] = 32'h0000_0001;
        send(1'b0, 0);
        finish_run("one");
        if (dat_q.size() > 0) chk("one_w0_hand", dat_q[0], 96'd3);

        // All ones: every coefficient 1023 -> 3326.
        for (int i = 0; i < 160; i++) mem[i] = 32'hFFFF_FFFF;
        send(1'b0, 0);
        finish_run("ones");
        if (dat_q.size() > 63) chk("ones_w63_hand", dat_q[63], {8{12'hCFE}});

        // Coefficient 512 at word 5 coefficient 0 (byte 51 = 0x02).
        for (int i = 0; i < 160; i++) mem[i] = 32'h0;
        mem[12] = 32'h0200_0000;
        send(1'b0, 0);
        finish_run("c512");
        if (dat_q.size() > 5) begin
            chk("c512_w5_hand", dat_q[5], 96'd1665);
            chk("c512_w4_hand", dat_q[4], 96'd0);
        end

        // Random data with random valid gaps.
        for (int i = 0; i < 160; i++) mem[i] = $urandom;
        send(1'b1, 0);
        finish_run("rand");

        // Reset mid-run after 20 writes, then a fresh run.
        send(1'b0, 20);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_outready", ct_outready, 1'b0);
        chk("midrst_wad", ct_WAd, 6'd0);
        @(posedge clk); #1 rst = 1'b0;
        clear_log();
        repeat (10) @(negedge clk);
        chk("midrst_nowrites", wad_q.size(), 0);
        chk("midrst_nodone", done_cnt, 0);
        for (int i = 0; i < 160; i++) mem[i] = $urandom;
        send(1'b0, 0);
        finish_run("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
